// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the counter-side controller and the
// binary-to-BCD converter.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 28,
   parameter int DIGITS = 9
) ();
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [DIGITS*4-1:0]   bcd_out;
   logic [DIGITS-1:0]     digit_en;

   modport master (
      output start,
      output bin_in,
      input  busy,
      input  done,
      input  bcd_out,
      input  digit_en
   );

   modport slave (
      input  start,
      input  bin_in,
      output busy,
      output done,
      output bcd_out,
      output digit_en
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock,
// with a leading-zero blanking mask for the display driver.
module bin2bcd_seq #(
   parameter int WIDTH  = 28,
   parameter int DIGITS = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   bin2bcd_seq_if.slave  bus
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [DIGITS-1:0] EN_RESET = {{(DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Correct every digit that would overflow past 9 when doubled.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            res[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return res;
   endfunction

   // Digit i is shown when it or any more significant digit is nonzero;
   // the units digit is always shown.
   function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
      logic [DIGITS-1:0] en;
      logic              seen;
      seen = 1'b0;
      en   = {DIGITS{1'b0}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen  = seen | (bcd[i*4 +: 4] != 4'd0);
         en[i] = seen;
      end
      en[0] = 1'b1;
      return en;
   endfunction

   state_t              state_r, state_s;
   logic [WIDTH-1:0]    bin_shift_r, bin_shift_s;
   logic [BCD_W-1:0]    bcd_work_r, bcd_work_s;
   logic [BCD_W-1:0]    adj_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [BCD_W-1:0]    bcd_out_r, bcd_out_s;
   logic [DIGITS-1:0]   digit_en_r, digit_en_s;
   logic                done_r, done_s;
   logic                busy_r, busy_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, datapath and output-register next values.
   always_comb begin
      state_s     = state_r;
      bin_shift_s = bin_shift_r;
      bcd_work_s  = bcd_work_r;
      cnt_s       = cnt_r;
      bcd_out_s   = bcd_out_r;
      digit_en_s  = digit_en_r;
      done_s      = 1'b0;
      busy_s      = busy_r;
      adj_s       = add3_digits(bcd_work_r);

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               bin_shift_s = bus.bin_in;
               bcd_work_s  = {BCD_W{1'b0}};
               cnt_s       = {CNT_W{1'b0}};
               busy_s      = 1'b1;
               state_s     = SHIFT;
            end else begin
               busy_s      = 1'b0;
            end
         end
         SHIFT: begin
            {bcd_work_s, bin_shift_s} = {adj_s, bin_shift_r} << 1;
            cnt_s  = cnt_r + CNT_W'(1);
            busy_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            // Final shift already happened; publish the result uncorrected.
            bcd_out_s  = bcd_work_r;
            digit_en_s = blank_mask(bcd_work_r);
            done_s     = 1'b1;
            busy_s     = 1'b0;
            state_s    = IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // Working registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_shift_r <= {WIDTH{1'b0}};
         bcd_work_r  <= {BCD_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         bcd_out_r   <= {BCD_W{1'b0}};
         digit_en_r  <= EN_RESET;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         bin_shift_r <= bin_shift_s;
         bcd_work_r  <= bcd_work_s;
         cnt_r       <= cnt_s;
         bcd_out_r   <= bcd_out_s;
         digit_en_r  <= digit_en_s;
         done_r      <= done_s;
         busy_r      <= busy_s;
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.bcd_out  = bcd_out_r;
   assign bus.digit_en = digit_en_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

   typedef struct packed {
      logic [35:0] bcd;
      logic [8:0]  en;
      logic [31:0] at;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] cyc;
   int          total;
   int          passed;
   exp_t        sb[$];
   logic        prev_done;
   exp_t        mon_e;
   logic [31:0] k;

   bin2bcd_seq_if #(.WIDTH(28), .DIGITS(9)) bus ();

   bin2bcd_seq #(.WIDTH(28), .DIGITS(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done <= 1'b0;
      end else begin
         if (bus.done) begin
            check("done_pulse_width", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
               check("unexpected_done", {63'd0, bus.done}, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("bcd_out", {28'd0, bus.bcd_out}, {28'd0, mon_e.bcd});
               check("digit_en", {55'd0, bus.digit_en}, {55'd0, mon_e.en});
               check("latency", {32'd0, cyc}, {32'd0, mon_e.at});
               check("busy_with_done", {63'd0, bus.busy}, 64'd0);
            end
         end
         prev_done <= bus.done;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
      check({tag, "_done"}, {63'd0, bus.done}, 64'd0);
      check({tag, "_bcd"}, {28'd0, bus.bcd_out}, 64'd0);
      check({tag, "_en"}, {55'd0, bus.digit_en}, 64'd1);
   endtask

   task automatic issue(input logic [27:0] v, input logic [35:0] eb, input logic [8:0] ee);
      exp_t e;
      @(negedge clk);
      bus.bin_in = v;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      k    = cyc;
      e.bcd = eb;
      e.en  = ee;
      e.at  = cyc + 32'd29;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      check("drain", 64'(sb.size()), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      total     = 0;
      passed    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.bin_in = 28'($urandom);

      // Reset with start asserted and random input.
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n     = 1'b1;
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check_idle("post_reset");

      issue(28'd0, 36'h000000000, 9'b000000001);
      drain(40);
      issue(28'd12345678, 36'h012345678, 9'b011111111);
      drain(40);
      repeat (5) @(negedge clk);
      check("hold_bcd", {28'd0, bus.bcd_out}, {28'd0, 36'h012345678});
      issue(28'd268435455, 36'h268435455, 9'h1FF);
      drain(40);

      // Extra starts during a conversion must be ignored.
      issue(28'd1000, 36'h000001000, 9'b000001111);
      for (int c = 2; c <= 28; c++) begin
         bus.bin_in = 28'd999;
         bus.start  = (c == 5 || c == 20) ? 1'b1 : 1'b0;
         if (c == 5 || c == 20) check("busy_mid", {63'd0, bus.busy}, 64'd1);
         @(negedge clk);
      end
      bus.start = 1'b0;
      drain(40);
      repeat (35) @(negedge clk);

      // Start held high: one result every 30 cycles.
      @(negedge clk);
      bus.bin_in = 28'd7;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      for (int j = 0; j < 3; j++) begin
         e.bcd = 36'h7;
         e.en  = 9'b1;
         e.at  = k + 32'd29 + 32'(30 * j);
         sb.push_back(e);
      end
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      bus.start = 1'b0;
      drain(5);
      repeat (35) @(negedge clk);

      // Reset mid-conversion aborts; no result may appear.
      @(negedge clk);
      bus.bin_in = 28'd500000;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("busy_before_abort", {63'd0, bus.busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_idle("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (35) @(negedge clk);
      check_idle("after_abort");
      issue(28'd42, 36'h42, 9'b11);
      drain(40);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
